// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state type, frame constants and the baud divider helper.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

   localparam int unsigned DATA_BITS  = 8;
   localparam int unsigned OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_RX_PARITY_EN
      StParity,
`endif
      StStop,
      StWaitHigh
   } rx_state_t;

   // Clocks per oversample tick, floored, never below 1.
   function automatic int unsigned baud_div(input int unsigned clk_freq,
                                            input int unsigned baud_rate);
      int unsigned d;
      d = clk_freq / (baud_rate * OVERSAMPLE);
      return (d == 0) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider: one-cycle tick every Div clocks (Div=1 gives a tick every clock).
module uart_baud_tick #(
   parameter int unsigned Div = 1
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = (cnt_q == CntW'(Div - 1));
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling 8N1 UART receiver with registered valid/frame_err strobes.
// Define UART_RX_PARITY_EN to expect an even-parity bit after bit 7 and report parity_err.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned BAUD_RATE  = 9600,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy
);

   localparam int unsigned Div  = baud_div(CLK_FREQ, BAUD_RATE);
   localparam int unsigned CntW = $clog2(OVERSAMPLE);
   localparam logic [CntW-1:0] MidCnt  = CntW'(OVERSAMPLE / 2 - 1);
   localparam logic [CntW-1:0] EndCnt  = CntW'(OVERSAMPLE - 1);
   localparam logic [2:0]      LastIdx = 3'(DATA_BITS - 1);

   logic            tick;
   logic [1:0]      sync_q;
   logic            rx_s;
   rx_state_t       state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic            perr_q, perr_d;
   logic            par_q, par_d;
`endif

   uart_baud_tick #(
      .Div(Div)
   ) u_baud_tick (
      .clk  (clk),
      .reset(reset),
      .tick (tick)
   );

   assign rx_s = sync_q[1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d  = 1'b0;
      par_d   = par_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (tick && !rx_s) begin
               state_d = StStart;
               cnt_d   = '0;
            end
         end
         StStart: begin
            if (tick) begin
               if (cnt_q == MidCnt) begin
                  cnt_d   = '0;
                  idx_d   = '0;
                  state_d = rx_s ? StIdle : StData;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StData: begin
            if (tick) begin
               if (cnt_q == EndCnt) begin
                  cnt_d          = '0;
                  shift_d[idx_q] = rx_s;
                  if (idx_q == LastIdx) begin
`ifdef UART_RX_PARITY_EN
                     state_d = StParity;
`else
                     state_d = StStop;
`endif
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (tick) begin
               if (cnt_q == EndCnt) begin
                  cnt_d   = '0;
                  par_d   = rx_s;
                  state_d = StStop;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
`endif
         StStop: begin
            if (tick) begin
               if (cnt_q == EndCnt) begin
                  cnt_d  = '0;
                  data_d = shift_q;
                  // A bad stop bit wins over a parity mismatch.
                  if (rx_s) begin
                     state_d = StIdle;
`ifdef UART_RX_PARITY_EN
                     if ((^shift_q) != par_q) perr_d  = 1'b1;
                     else                     valid_d = 1'b1;
`else
                     valid_d = 1'b1;
`endif
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = StWaitHigh;
                  end
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StWaitHigh: begin
            if (rx_s) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q  <= 2'b11;
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q  <= 1'b0;
         par_q   <= 1'b0;
`endif
      end else begin
         sync_q  <= {sync_q[0], rx};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         perr_q  <= perr_d;
         par_q   <= par_d;
`endif
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule
